sys_array_scheduler: RTL and testbench

//  Round-robin scheduler sharing one sys_array_fetcher among NUM_REQ requesters.

---
 rtl/sys_array_pkg.sv | 21 ++
 rtl/sys_array_scheduler_if.sv | 31 +++
 rtl/sys_array_scheduler_rr_arbiter.sv | 31 +++
 rtl/sys_array_scheduler.sv | 152 +++++++++++++++
 tb/tb_sys_array_scheduler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_array_pkg.sv
// Shared types and width helpers for the systolic-array fetcher scheduler.
// Holds the scheduler FSM state encoding and the index-width helper.
package sys_array_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } sched_state_t;

  // Index width that never collapses to zero bits for small counts.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_IDX_W   = idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/sys_array_scheduler_if.sv
// Requester/fetcher bundle of the scheduler; slave = scheduler side, master = requesters + fetcher.
// Handshake: req[k] is a level held until done[k] pulses for one cycle while grant[k] is still high.
interface sys_array_scheduler_if
  import sys_array_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
);
  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] keep_w;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] done;
  logic               busy;
  logic               err_timeout;
  logic               fetch_weights_load;
  logic               fetch_start_comp;
  logic               fetch_ready;

  modport slave (
    input  req, keep_w, fetch_ready,
    output grant, grant_idx, done, busy, err_timeout, fetch_weights_load, fetch_start_comp
  );

  modport master (
    output req, keep_w, fetch_ready,
    input  grant, grant_idx, done, busy, err_timeout, fetch_weights_load, fetch_start_comp
  );

endinterface

// File: rtl/sys_array_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping at N.
module rr_arbiter
  import sys_array_pkg::*;
#(
  parameter  int N  = DEF_NUM_REQ,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx,
  output logic [N-1:0]  o_onehot
);

  always_comb begin
    int j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = (int'(i_ptr) + i) % N;
      if (!o_found && i_req[j]) begin
        o_found = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

  assign o_onehot = o_found ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/sys_array_scheduler.sv
// Round-robin scheduler sharing one systolic-array fetcher; skips weight reload on same-owner reruns.
// Optional WAIT watchdog is built when SYS_SCHED_TIMEOUT_EN is defined.
module sys_array_scheduler
  import sys_array_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int WLOAD_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sys_array_scheduler_if.slave  bus,
  output sched_state_t          o_state
);

  localparam int IDX_W  = idx_w(NUM_REQ);
  localparam int WCNT_W = idx_w(WLOAD_CYCLES);

  sched_state_t       r_state, w_next;
  logic [NUM_REQ-1:0] r_grant, r_done;
  logic [IDX_W-1:0]   r_grant_idx, r_ptr, r_last_idx;
  logic               r_busy, r_err, r_wload, r_start, r_wvalid, r_blank;
  logic [WCNT_W-1:0]  r_wcnt;

  logic               w_found, w_timeout;
  logic [IDX_W-1:0]   w_pick_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_pick_onehot;

  logic [NUM_REQ-1:0] w_grant_d, w_done_d;
  logic [IDX_W-1:0]   w_idx_d, w_ptr_d, w_last_d;
  logic               w_busy_d, w_wload_d, w_start_d, w_err_d, w_wvalid_d;

`ifdef SYS_SCHED_TIMEOUT_EN
  localparam int TCNT_W = idx_w(TIMEOUT_CYCLES);
  logic [TCNT_W-1:0]  r_tcnt;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot)
  );

  assign w_ptr_nxt = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:   if (w_found)
                w_next = (bus.keep_w[w_pick_idx] && r_wvalid && (r_last_idx == w_pick_idx))
                         ? START : LOAD_W;
      LOAD_W: if (r_wcnt == WCNT_W'(WLOAD_CYCLES - 1)) w_next = START;
      START:  w_next = WAIT;
      WAIT: begin
        // The first WAIT cycle can still see the previous job's ready.
        if (!r_blank && bus.fetch_ready) w_next = DONE;
`ifdef SYS_SCHED_TIMEOUT_EN
        else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
`endif
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are computed for the coming state and registered below.
  always_comb begin
    w_grant_d  = r_grant;
    w_idx_d    = r_grant_idx;
    w_done_d   = '0;
    w_busy_d   = (w_next != IDLE);
    w_wload_d  = (w_next == LOAD_W);
    w_start_d  = (w_next == START);
    w_err_d    = w_timeout;
    w_wvalid_d = r_wvalid;
    w_last_d   = r_last_idx;
    w_ptr_d    = r_ptr;
    if (r_state == IDLE && w_found) begin
      w_grant_d = w_pick_onehot;
      w_idx_d   = w_pick_idx;
      if (w_next == LOAD_W) begin
        w_wvalid_d = 1'b1;
        w_last_d   = w_pick_idx;
      end
    end
    if (w_next == DONE) w_done_d = r_grant;
    if (r_state == DONE || w_timeout) begin
      w_grant_d = '0;
      w_ptr_d   = w_ptr_nxt;
    end
    if (w_timeout) w_wvalid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_wload     <= 1'b0;
      r_start     <= 1'b0;
      r_wvalid    <= 1'b0;
      r_last_idx  <= '0;
      r_ptr       <= '0;
      r_wcnt      <= '0;
      r_blank     <= 1'b0;
    end else begin
      r_grant     <= w_grant_d;
      r_grant_idx <= w_idx_d;
      r_done      <= w_done_d;
      r_busy      <= w_busy_d;
      r_err       <= w_err_d;
      r_wload     <= w_wload_d;
      r_start     <= w_start_d;
      r_wvalid    <= w_wvalid_d;
      r_last_idx  <= w_last_d;
      r_ptr       <= w_ptr_d;
      r_wcnt      <= (r_state == LOAD_W) ? r_wcnt + 1'b1 : '0;
      r_blank     <= (r_state == START);
    end
  end

`ifdef SYS_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)             r_tcnt <= '0;
    else if (r_state == WAIT) r_tcnt <= r_tcnt + 1'b1;
    else                      r_tcnt <= '0;
  end
`endif

  assign bus.grant              = r_grant;
  assign bus.grant_idx          = r_grant_idx;
  assign bus.done               = r_done;
  assign bus.busy               = r_busy;
  assign bus.err_timeout        = r_err;
  assign bus.fetch_weights_load = r_wload;
  assign bus.fetch_start_comp   = r_start;
  assign o_state                = r_state;

endmodule

// File: tb/tb_sys_array_scheduler.sv
// Directed bench for sys_array_scheduler with a behavioural fetcher and a done-ordered scoreboard.
module tb_sys_array_scheduler;
  import sys_array_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         never_ready;
  int unsigned  f_cnt;
  sched_state_t dut_state;
  int           n_tests;
  int           n_fail;
  int           loads;
  int           n;
  logic [2:0]   exp_q[$];   // {expect_weight_load, requester index}

  sys_array_scheduler_if #(.NUM_REQ(4)) bus ();

  sys_array_scheduler #(
    .NUM_REQ        (4),
    .WLOAD_CYCLES   (1),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .o_state (dut_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetcher model: ready drops the cycle after start and returns 15 cycles after start.
  always @(posedge clk) begin
    if (!reset_n) begin
      bus.fetch_ready <= 1'b1;
      f_cnt           <= 0;
    end else if (bus.fetch_start_comp) begin
      bus.fetch_ready <= 1'b0;
      f_cnt           <= 14;
    end else if (f_cnt != 0) begin
      f_cnt <= f_cnt - 1;
      if (f_cnt == 1 && !never_ready) bus.fetch_ready <= 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.done == '0 && cnt < max);
    check("done_seen", 32'(bus.done != '0), 32'd1);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [2:0] e;
    if (reset_n) begin
      if (bus.grant == '0) loads = 0;
      if (bus.fetch_weights_load) loads++;
      if (bus.done != '0) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_done_owner", 32'(bus.done), 32'd1 << e[1:0]);
          check("sb_weight_load", 32'(loads != 0), 32'(e[2]));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int order [5];
    order       = '{0, 1, 2, 3, 0};
    n_tests     = 0;
    n_fail      = 0;
    loads       = 0;
    never_ready = 1'b0;
    reset_n     = 1'b0;
    bus.req     = '0;
    bus.keep_w  = '0;
    repeat (3) tick();

    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err_timeout), 32'd0);
    check("rst_fetch", 32'({bus.fetch_weights_load, bus.fetch_start_comp}), 32'd0);
    check("rst_state", 32'(dut_state), 32'(IDLE));
    reset_n = 1'b1;
    tick();

    // 1: single job with weight load
    exp_q.push_back({1'b1, 2'd0});
    bus.req = 4'b0001;
    tick();
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_wload", 32'(bus.fetch_weights_load), 32'd1);
    check("t1_state", 32'(dut_state), 32'(LOAD_W));
    tick();
    check("t1_start", 32'(bus.fetch_start_comp), 32'd1);
    check("t1_wload_off", 32'(bus.fetch_weights_load), 32'd0);
    wait_done(40, n);
    check("t1_latency", 32'(n), 32'd16);
    check("t1_grant_at_done", 32'(bus.grant), 32'h1);
    bus.req = '0;
    tick();
    check("t1_grant_idle", 32'(bus.grant), 32'd0);
    check("t1_busy_idle", 32'(bus.busy), 32'd0);

    // re-reset so the rotation starts at requester 0
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // 2: all requesting, rotation 0,1,2,3,0
    for (int j = 0; j < 5; j++) exp_q.push_back({1'b1, 2'(order[j])});
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(40, n);
      check("t2_order", 32'(bus.done), 32'd1 << order[j]);
      if (j == 4) bus.req = '0;
      tick();
      check("t2_gap_grant", 32'(bus.grant), 32'd0);
    end

    // 3: weight reuse for requester 2, then reload after requester 1 ran
    exp_q.push_back({1'b1, 2'd2});
    bus.req = 4'b0100;
    wait_done(40, n);
    bus.req = '0;
    tick();
    exp_q.push_back({1'b0, 2'd2});
    bus.req    = 4'b0100;
    bus.keep_w = 4'b0100;
    tick();
    check("t3_reuse_grant", 32'(bus.grant), 32'h4);
    check("t3_reuse_no_wload", 32'(bus.fetch_weights_load), 32'd0);
    check("t3_reuse_start", 32'(bus.fetch_start_comp), 32'd1);
    wait_done(40, n);
    check("t3_reuse_latency", 32'(n), 32'd16);
    bus.req    = '0;
    bus.keep_w = '0;
    tick();
    exp_q.push_back({1'b1, 2'd1});
    bus.req = 4'b0010;
    wait_done(40, n);
    bus.req = '0;
    tick();
    exp_q.push_back({1'b1, 2'd2});
    bus.req    = 4'b0100;
    bus.keep_w = 4'b0100;
    tick();
    check("t3_reload_wload", 32'(bus.fetch_weights_load), 32'd1);
    wait_done(40, n);
    bus.req    = '0;
    bus.keep_w = '0;
    tick();

    // 4: request dropped during WAIT still completes
    exp_q.push_back({1'b1, 2'd1});
    bus.req = 4'b0010;
    repeat (3) tick();
    check("t4_in_wait", 32'(dut_state), 32'(WAIT));
    bus.req = '0;
    wait_done(40, n);
    check("t4_done1", 32'(bus.done), 32'h2);
    repeat (5) tick();
    check("t4_no_grant", 32'(bus.grant), 32'd0);
    check("t4_not_busy", 32'(bus.busy), 32'd0);

    // 5: reset mid-job, then reload on the next job
    bus.req    = 4'b0010;
    bus.keep_w = 4'b0010;
    tick();
    check("t5_skip_load", 32'(dut_state), 32'(START));
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    check("t5_rst_grant", 32'(bus.grant), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_done", 32'(bus.done), 32'd0);
    check("t5_rst_state", 32'(dut_state), 32'(IDLE));
    exp_q.push_back({1'b1, 2'd1});
    reset_n = 1'b1;
    tick();
    check("t5_reload", 32'(bus.fetch_weights_load), 32'd1);
    check("t5_grant", 32'(bus.grant), 32'h2);
    wait_done(40, n);
    bus.req    = '0;
    bus.keep_w = '0;
    tick();

    // 6: fetcher never becomes ready
    never_ready = 1'b1;
    bus.req     = 4'b0001;
    tick();
    tick();
`ifdef SYS_SCHED_TIMEOUT_EN
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.err_timeout && n < 40);
    check("t6_err_seen", 32'(bus.err_timeout), 32'd1);
    check("t6_err_delay", 32'(n), 32'd17);
    check("t6_err_grant", 32'(bus.grant), 32'd0);
    check("t6_err_done", 32'(bus.done), 32'd0);
    never_ready = 1'b0;
    exp_q.push_back({1'b1, 2'd0});
    bus.keep_w  = 4'b0001;
    tick();
    check("t6_reload", 32'(bus.fetch_weights_load), 32'd1);
    check("t6_err_pulse", 32'(bus.err_timeout), 32'd0);
    wait_done(40, n);
    bus.req    = '0;
    bus.keep_w = '0;
    tick();
`else
    repeat (100) tick();
    check("t6_still_wait", 32'(dut_state), 32'(WAIT));
    check("t6_busy", 32'(bus.busy), 32'd1);
    check("t6_grant", 32'(bus.grant), 32'h1);
    check("t6_no_err", 32'(bus.err_timeout), 32'd0);
    reset_n     = 1'b0;
    bus.req     = '0;
    tick();
    reset_n     = 1'b1;
    never_ready = 1'b0;
    tick();
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
